// File: rtl/dmac_arb_n.sv
// N-channel DMA arbiter and burst sequencer: picks an eligible channel (round-robin or
// fixed priority), grants it up to BURST beats, and tracks per-channel remaining beats.
module dmac_arb_n #(
   parameter int NCH   = 4,
   parameter int CNT_W = 10,
   parameter int BURST = 4,
   parameter int RR    = 1
) (
   input  logic                     HCLK,
   input  logic                     HRESETn,
   input  logic [NCH-1:0]           ch_en,
   input  logic [NCH-1:0]           start,
   input  logic [NCH*CNT_W-1:0]     size_i,
   input  logic [NCH-1:0]           req,
   input  logic [NCH-1:0]           fifo_full,
   input  logic                     beat_done,
   input  logic                     hready_in,
   output logic [NCH-1:0]           grant,
   output logic [$clog2(NCH)-1:0]   grant_id,
   output logic [NCH-1:0]           ack,
   output logic [NCH-1:0]           ch_done,
   output logic [CNT_W-1:0]         cur_rem,
   output logic                     busy,
   output logic [1:0]               fsm_state
);
   localparam int IDW = $clog2(NCH);

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] rem [NCH];
   logic [IDW-1:0]   g, rr_ptr, win;
   logic [7:0]       beat_cnt, cnt_nxt;
   logic [NCH-1:0]   elig;
   logic             any_elig, beat, end_burst;
   logic [CNT_W-1:0] rem_g, rem_g_nxt;

   always_comb begin
      for (int i = 0; i < NCH; i++)
         elig[i] = ch_en[i] & req[i] & (rem[i] != '0) & ~fifo_full[i];
   end

   // Search starts at rr_ptr for round-robin, at 0 for fixed priority.
   always_comb begin
      int idx;
      idx      = 0;
      win      = '0;
      any_elig = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         idx = (RR != 0) ? ((int'(rr_ptr) + k) % NCH) : k;
         if (!any_elig && elig[idx]) begin
            win      = IDW'(idx);
            any_elig = 1'b1;
         end
      end
   end

   assign beat      = (state == GRANT) && beat_done && hready_in;
   assign rem_g     = rem[g];
   assign rem_g_nxt = (beat && rem_g != '0) ? rem_g - 1'b1 : rem_g;
   assign cnt_nxt   = beat ? beat_cnt + 8'd1 : beat_cnt;
   assign end_burst = (cnt_nxt == 8'(BURST)) || (rem_g_nxt == '0) || fifo_full[g] || !req[g];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_elig) state_nxt = GRANT;
         GRANT: begin
            // Losing the enable aborts silently; no ack and the count is kept.
            if (!ch_en[g])      state_nxt = IDLE;
            else if (end_burst) state_nxt = RELEASE;
         end
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state    <= IDLE;
         g        <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         for (int i = 0; i < NCH; i++) rem[i] <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && any_elig) begin
            g        <= win;
            beat_cnt <= '0;
         end else if (beat) begin
            beat_cnt <= cnt_nxt;
         end
         // The owning channel's count is frozen against start for the whole grant/release.
         for (int i = 0; i < NCH; i++) begin
            if (beat && g == IDW'(i))
               rem[i] <= rem_g_nxt;
            else if (start[i] && !(state != IDLE && g == IDW'(i)))
               rem[i] <= size_i[i*CNT_W +: CNT_W];
         end
         if (state == RELEASE && RR != 0)
            rr_ptr <= (g == IDW'(NCH-1)) ? '0 : g + 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         grant[i]   = (state == GRANT)   && (g == IDW'(i));
         ack[i]     = (state == RELEASE) && (g == IDW'(i));
         ch_done[i] = (state == RELEASE) && (g == IDW'(i)) && (rem_g == '0);
      end
   end

   assign busy      = (state != IDLE);
   assign grant_id  = busy ? g : '0;
   assign cur_rem   = rem_g;
   assign fsm_state = state;
endmodule
